// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART TX core among
// NUM_REQ requesters. It latches the winning byte and parity mode, pulses
// tx_start, and holds the TX inputs stable until the frame is done.
//
// Ports:
//   clk, rst          rising-edge clock, async active-high reset
//   req_valid/ready   per-requester handshake (ready is one-hot, IDLE only)
//   req_data          packed payloads, requester i at [i*DATA_W +: DATA_W]
//   req_parity_en     per-requester parity enable
//   req_even_parity   per-requester parity sense (1 = even, 0 = odd)
//   tx_start          one-cycle launch pulse
//   tx_data           latched byte, held until the next grant
//   tx_parity_en      latched parity enable
//   tx_even_parity    latched parity sense
//   tx_busy, tx_done  transmitter status (busy level, done pulse)
//   grant_id          current or last granted requester
//   active            high whenever the arbiter is not idle
//   timeout_err       one-cycle pulse when tx_busy never arrived
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_parity_en,
    input  logic [NUM_REQ-1:0]         req_even_parity,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          tx_data,
    output logic                       tx_parity_en,
    output logic                       tx_even_parity,
    input  logic                       tx_busy,
    input  logic                       tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active,
    output logic                       timeout_err
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_LAUNCH,
        ARB_WAIT_BUSY,
        ARB_WAIT_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]       grant_q, grant_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                par_en_q, par_en_d;
    logic                even_q, even_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                tmo_q, tmo_d;

    logic [PW-1:0]       winner;
    logic                win_found;
    logic                accept;

    // Scan from the farthest offset down so the requester closest to
    // rr_ptr is the last one written and therefore wins.
    always_comb begin
        winner    = rr_ptr_q;
        win_found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int s;
            s = int'(rr_ptr_q) + k;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            if (req_valid[PW'(s)]) begin
                winner    = PW'(s);
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        par_en_d = par_en_q;
        even_d   = even_q;
        cnt_d    = cnt_q;
        tmo_d    = 1'b0;
        tx_start = 1'b0;
        accept   = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (win_found) begin
                    accept   = 1'b1;
                    data_d   = req_data[winner*DATA_W +: DATA_W];
                    par_en_d = req_parity_en[winner];
                    even_d   = req_even_parity[winner];
                    grant_d  = winner;
                    if (winner == PW'(NUM_REQ - 1)) rr_ptr_d = '0;
                    else rr_ptr_d = winner + 1'b1;
                    state_d  = ARB_LAUNCH;
                end
            end
            ARB_LAUNCH: begin
                tx_start = 1'b1;
                cnt_d    = '0;
                state_d  = ARB_WAIT_BUSY;
            end
            ARB_WAIT_BUSY: begin
                // done wins so a short or missed busy still completes
                if (tx_done) begin
                    state_d = ARB_IDLE;
                end else if (tx_busy) begin
                    state_d = ARB_WAIT_DONE;
                end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ARB_WAIT_DONE: begin
                if (tx_done) state_d = ARB_IDLE;
            end
        endcase
    end

    // Gated by rst so ready stays low while reset holds the FSM in IDLE.
    always_comb begin
        req_ready = '0;
        if (accept && !rst) req_ready[winner] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            data_q   <= '0;
            par_en_q <= 1'b0;
            even_q   <= 1'b0;
            cnt_q    <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            par_en_q <= par_en_d;
            even_q   <= even_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
        end
    end

    assign tx_data        = data_q;
    assign tx_parity_en   = par_en_q;
    assign tx_even_parity = even_q;
    assign grant_id       = grant_q;
    assign active         = (state_q != ARB_IDLE);
    assign timeout_err    = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed, table-driven bench for uart_tx_arbiter
// with a hand-driven TX model (busy/done) and a few corner sequences.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data;
    logic [3:0]  req_parity_en;
    logic [3:0]  req_even_parity;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_parity_en;
    logic        tx_even_parity;
    logic        tx_busy = 1'b0;
    logic        tx_done = 1'b0;
    logic [1:0]  grant_id;
    logic        active;
    logic        timeout_err;

    logic [7:0]  pay [4] = '{8'h0F, 8'h5A, 8'hA5, 8'hC3};
    logic [3:0]  pen = 4'b1110;
    logic [3:0]  pev = 4'b0101;

    int n_chk = 0;
    int n_fail = 0;

    assign req_data        = {pay[3], pay[2], pay[1], pay[0]};
    assign req_parity_en   = pen;
    assign req_even_parity = pev;

    uart_tx_arbiter #(
        .NUM_REQ(4),
        .DATA_W(8),
        .BUSY_TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_parity_en(req_parity_en),
        .req_even_parity(req_even_parity),
        .req_ready(req_ready),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_parity_en(tx_parity_en),
        .tx_even_parity(tx_even_parity),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .grant_id(grant_id),
        .active(active),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 0);
        chk({tag, "_start"}, 32'(tx_start), 0);
        chk({tag, "_data"}, 32'(tx_data), 0);
        chk({tag, "_pen"}, 32'(tx_parity_en), 0);
        chk({tag, "_pev"}, 32'(tx_even_parity), 0);
        chk({tag, "_gid"}, 32'(grant_id), 0);
        chk({tag, "_active"}, 32'(active), 0);
        chk({tag, "_tmo"}, 32'(timeout_err), 0);
    endtask

    // mode 0: normal frame, 1: early done, 2: busy timeout,
    // 3: stop in WAIT_DONE (caller continues)
    task automatic xfer(input logic [3:0] mask, input int g,
                        input int mode, input int dw);
        req_valid = mask;
        #1;
        chk("idle_ready", 32'(req_ready), 32'(1 << g));
        chk("idle_active", 32'(active), 0);
        @(negedge clk);
        chk("launch_start", 32'(tx_start), 1);
        chk("launch_data", 32'(tx_data), 32'(pay[g]));
        chk("launch_pen", 32'(tx_parity_en), 32'(pen[g]));
        chk("launch_pev", 32'(tx_even_parity), 32'(pev[g]));
        chk("launch_gid", 32'(grant_id), 32'(g));
        chk("launch_active", 32'(active), 1);
        chk("launch_ready", 32'(req_ready), 0);
        chk("launch_tmo", 32'(timeout_err), 0);
        if (mode == 0 || mode == 3) tx_busy = 1'b1;
        @(negedge clk);
        chk("wb_start", 32'(tx_start), 0);
        chk("wb_active", 32'(active), 1);
        if (mode == 1) begin
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            chk("early_active", 32'(active), 0);
            chk("early_tmo", 32'(timeout_err), 0);
        end else if (mode == 2) begin
            for (int c = 1; c < 16; c++) begin
                @(negedge clk);
                chk("tmo_wait_active", 32'(active), 1);
                chk("tmo_wait_err", 32'(timeout_err), 0);
            end
            @(negedge clk);
            chk("tmo_err", 32'(timeout_err), 1);
            chk("tmo_active", 32'(active), 0);
        end else begin
            @(negedge clk);
            chk("wd_ready", 32'(req_ready), 0);
            chk("wd_active", 32'(active), 1);
            if (mode == 3) return;
            if (dw >= 2) tx_busy = 1'b0;
            repeat (dw) @(negedge clk);
            chk("wd_hold_active", 32'(active), 1);
            tx_done = 1'b1;
            tx_busy = 1'b0;
            @(negedge clk);
            tx_done = 1'b0;
            chk("done_active", 32'(active), 0);
            chk("done_tmo", 32'(timeout_err), 0);
            chk("done_data_hold", 32'(tx_data), 32'(pay[g]));
            chk("done_start", 32'(tx_start), 0);
        end
        req_valid = '0;
    endtask

    typedef struct {
        logic [3:0] valid;
        int         gnt;
        int         dw;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{4'b0100, 2, 0};
        tbl[1]  = '{4'b1000, 3, 0};
        tbl[2]  = '{4'b1010, 1, 3};
        tbl[3]  = '{4'b1010, 3, 0};
        tbl[4]  = '{4'b1111, 0, 9};
        tbl[5]  = '{4'b1111, 1, 9};
        tbl[6]  = '{4'b1111, 2, 9};
        tbl[7]  = '{4'b1111, 3, 9};
        tbl[8]  = '{4'b1111, 0, 9};
        tbl[9]  = '{4'b0001, 0, 1};
        tbl[10] = '{4'b0110, 1, 0};
        tbl[11] = '{4'b0011, 0, 2};

        @(negedge clk);
        #1;
        chk_zero_outs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_active", 32'(active), 0);

        for (int i = 0; i < 12; i++)
            xfer(tbl[i].valid, tbl[i].gnt, 0, tbl[i].dw);

        // busy never arrives, then the next requester gets the TX
        xfer(4'b0010, 1, 2, 0);
        xfer(4'b0110, 2, 0, 0);

        xfer(4'b1000, 3, 1, 0);

        // reset while in WAIT_DONE: pointer must restart at 0
        xfer(4'b0100, 2, 3, 0);
        rst = 1'b1;
        #1;
        chk_zero_outs("midreset");
        req_valid = '0;
        tx_busy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        xfer(4'b1001, 0, 0, 0);
        xfer(4'b1001, 3, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
